// File: rtl/uart_rx_fifo_if.sv
// uart_rx_fifo_if: push/pop/status bundle between a UART receiver, its consumer and the receive FIFO
interface uart_rx_fifo_if #(
    parameter int DATA_WIDTH = 8,
    parameter int DEPTH      = 16
);
    logic                    wr_en;
    logic [DATA_WIDTH-1:0]   wr_data;
    logic                    rd_en;
    logic [DATA_WIDTH-1:0]   rd_data;
    logic                    empty;
    logic                    full;
    logic                    almost_full;
    logic [$clog2(DEPTH):0]  count;
    logic                    overrun;
    logic                    clr_overrun;
    modport master (
        output wr_en, wr_data, rd_en, clr_overrun,
        input  rd_data, empty, full, almost_full, count, overrun
    );
    modport slave (
        input  wr_en, wr_data, rd_en, clr_overrun,
        output rd_data, empty, full, almost_full, count, overrun
    );
endinterface

// File: rtl/uart_rx_fifo.sv
// uart_rx_fifo: first-word-fall-through receive FIFO with sticky overrun flag
module uart_rx_fifo #(
    parameter int DATA_WIDTH = 8,
    parameter int DEPTH      = 16,
    parameter int AF_LEVEL   = 12
) (
    input logic           clk,
    input logic           rst,
    uart_rx_fifo_if.slave bus
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    logic [AW-1:0]         wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]         count_q, count_d;
    logic                  overrun_q, overrun_d;
    logic [DATA_WIDTH-1:0] mem_q [DEPTH];
    logic                  empty, full, push, pop, drop;
    // A push into a full FIFO is still accepted when a pop frees the head slot in the same cycle
    always_comb begin
        empty     = count_q == '0;
        full      = count_q == CW'(DEPTH);
        pop       = bus.rd_en && !empty;
        push      = bus.wr_en && (!full || bus.rd_en);
        drop      = bus.wr_en && full && !bus.rd_en;
        wr_ptr_d  = push ? wr_ptr_q + 1'b1 : wr_ptr_q;
        rd_ptr_d  = pop ? rd_ptr_q + 1'b1 : rd_ptr_q;
        count_d   = count_q + CW'(push) - CW'(pop);
        overrun_d = drop || (overrun_q && !bus.clr_overrun);
    end
    // Pointer, occupancy and flag state, cleared asynchronously
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            count_q   <= '0;
            overrun_q <= 1'b0;
        end else begin
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            count_q   <= count_d;
            overrun_q <= overrun_d;
        end
    end
    // Storage array is not reset; stale entries are unreachable once count is zero
    always_ff @(posedge clk) begin
        if (push && !rst) mem_q[wr_ptr_q] <= bus.wr_data;
    end
    assign bus.rd_data     = empty ? '0 : mem_q[rd_ptr_q];
    assign bus.empty       = empty;
    assign bus.full        = full;
    assign bus.almost_full = count_q >= CW'(AF_LEVEL);
    assign bus.count       = count_q;
    assign bus.overrun     = overrun_q;
endmodule

// File: doc/uart_rx_fifo.md
UART_RX_FIFO -- requirements
Module: uart_rx_fifo

Interface
REQ-001 SHALL provide parameter DATA_WIDTH, default 8, byte width of stored receive data.
REQ-002 SHALL provide parameter DEPTH, default 16, number of entries; power of two, minimum 2.
REQ-003 SHALL provide parameter AF_LEVEL, default 12, count at or above which almost_full asserts.
REQ-004 SHALL have port clk  input  1  single clock; all state updates on its rising edge.
REQ-005 SHALL have port rst  input  1  asynchronous, active-high reset.
REQ-006 SHALL have port wr_en  input  1  one-cycle push strobe from the UART receiver (byte complete).
REQ-007 SHALL have port wr_data  input  DATA_WIDTH  received byte from the receiver's data output.
REQ-008 SHALL have port rd_en  input  1  pop strobe from the consumer.
REQ-009 SHALL have port rd_data  output  DATA_WIDTH  head-of-queue byte (first-word-fall-through).
REQ-010 SHALL have port empty  output  1  no entries stored.
REQ-011 SHALL have port full  output  1  DEPTH entries stored.
REQ-012 SHALL have port almost_full  output  1  count >= AF_LEVEL.
REQ-013 SHALL have port count  output  log2(DEPTH)+1  number of stored entries, 0..DEPTH.
REQ-014 SHALL have port overrun  output  1  sticky flag: a push was dropped because the FIFO was full.
REQ-015 SHALL have port clr_overrun  input  1  one-cycle clear of overrun.

Function
REQ-016 SHALL store entries in a DEPTH-entry register array addressed by write and read pointers of log2(DEPTH) bits that wrap from DEPTH-1 to 0.
REQ-017 SHALL, on wr_en with full=0, write wr_data at the write pointer and advance it by 1 at the same edge.
REQ-018 SHALL, on rd_en with empty=0, advance the read pointer by 1; the popped byte is rd_data during the cycle rd_en is high.
REQ-019 SHALL drive rd_data combinationally from the entry at the read pointer when empty=0, and all-zeros when empty=1.
REQ-020 SHALL present a byte on rd_data the cycle after the edge that wrote it into an empty FIFO (1-cycle write-to-read latency).
REQ-021 SHALL ignore rd_en when empty=1: no pointer, count or flag change.
REQ-022 SHALL, on wr_en with full=1 and no rd_en, drop wr_data, leave pointers unchanged and set overrun at that edge.
REQ-023 SHALL, on simultaneous wr_en and rd_en with full=1, pop the head and accept the write; count stays DEPTH, overrun unchanged.
REQ-024 SHALL, on simultaneous wr_en and rd_en with empty=1, accept the write only; count becomes 1.
REQ-025 SHALL, on simultaneous wr_en and rd_en with 0<count<DEPTH, perform both; count unchanged.
REQ-026 SHALL update count as +1 (push only), -1 (pop only), 0 (both or neither), never leaving 0..DEPTH.
REQ-027 SHALL derive empty=(count==0), full=(count==DEPTH), almost_full=(count>=AF_LEVEL), all from registered count.
REQ-028 SHALL clear overrun on clr_overrun; when a dropped push and clr_overrun coincide, set SHALL win.
REQ-029 SHALL keep stored data and order intact across any overrun event (no head corruption).

Reset
REQ-030 SHALL, while rst=1, asynchronously force both pointers and count to 0, empty=1, full=0, almost_full=0, overrun=0, rd_data=0.
REQ-031 SHALL discard all stored entries on reset mid-operation; array contents need not be cleared.
REQ-032 SHALL ignore wr_en, rd_en and clr_overrun while rst=1; first push accepted on the first rising edge after rst deasserts.

Verification
REQ-033 Reset then push 0x5A -> next cycle empty=0, count=1, rd_data=0x5A; pop -> empty=1, count=0, rd_data=0x00.
REQ-034 Push 0x00..0x0F (16 bytes) -> full=1, almost_full asserted at count 12; pop 16 -> bytes 0x00..0x0F in order, empty=1.
REQ-035 Fill to 16, push 0xEE without pop -> overrun=1, count=16, popped sequence still 0x00..0x0F with no 0xEE; clr_overrun -> overrun=0.
REQ-036 Full FIFO, simultaneous push 0xA5 and pop -> count=16, overrun=0, after 16 further pops 0xA5 is the last byte out.
REQ-037 Empty FIFO, simultaneous push 0x3C and pop -> count=1, rd_data=0x3C; pop on empty -> no change.
REQ-038 Push 20/pop 20 interleaved across pointer wrap, then assert rst with count=7 -> count=0, empty=1, overrun=0 immediately, no clock edge required.
